// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared constants and types for the UART bus arbiter.
//   UART_OFF_*   : UART controller register offsets (2 bits)
//   UART_OFF_IDLE: offset presented when no requester is granted. Status is
//                  read-only and side-effect free, unlike RX data, which pops.
//   arb_state_e  : arbiter lock state (IDLE_RR = no owner, LOCKED = owner valid)
package uart_arb_pkg;

  localparam logic [1:0] UART_OFF_BAUD   = 2'd0;
  localparam logic [1:0] UART_OFF_STATUS = 2'd1;
  localparam logic [1:0] UART_OFF_RXDATA = 2'd2;
  localparam logic [1:0] UART_OFF_TXDATA = 2'd3;
  localparam logic [1:0] UART_OFF_IDLE   = UART_OFF_STATUS;

  typedef enum logic {
    IDLE_RR = 1'b0,
    LOCKED  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational masked priority picker.
// The search starts at ptr and wraps modulo NumReq. The first set request
// bit wins.
//   req   in  NumReq  request vector (already masked by the caller)
//   ptr   in  PtrW    search start index (must be < NumReq)
//   gnt   out NumReq  one-hot winner (all zero when nothing requests)
//   valid out 1       a winner exists
module uart_rr_pick #(
  parameter  int NumReq = 2,
  localparam int PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req,
  input  logic [PtrW-1:0]   ptr,
  output logic [NumReq-1:0] gnt,
  output logic              valid
);

  logic [PtrW-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NumReq; i++) begin
      // Explicit modulo keeps the wrap correct for non-power-of-2 NumReq.
      idx = PtrW'((int'(ptr) + i) % NumReq);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_bus_arb.sv
// uart_bus_arb: shares one UART controller register port among NumReq
// requesters. Selection is round-robin with one grant per cycle. A requester
// can hold a bounded lock.
// Optional macro UART_ARB_PRIO_EN: when this macro is defined, requester 0
// beats round-robin whenever no other requester holds the lock. Requester-0
// priority grants do not move ptr.
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   req_i/we_i/lock_i [NumReq]        per-requester request, write, keep-lock
//   addr_i  [NumReq*2]                packed offsets, requester k at [2k+1:2k]
//   wdata_i [NumReq*BusDataWidth]     packed write data
//   gnt_o   [NumReq]                  one-hot combinational grant
//   rvalid_o[NumReq], rdata_o         response one cycle after the grant
//   uart_wr_en_o/addr_o/wdata_o       to UART bus port
//   uart_rdata_i                      from UART bus port
module uart_bus_arb
  import uart_arb_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int BusDataWidth  = 32,
  parameter int LockMaxCycles = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumReq-1:0]              req_i,
  input  logic [NumReq-1:0]              we_i,
  input  logic [NumReq-1:0]              lock_i,
  input  logic [NumReq*2-1:0]            addr_i,
  input  logic [NumReq*BusDataWidth-1:0] wdata_i,
  output logic [NumReq-1:0]              gnt_o,
  output logic [NumReq-1:0]              rvalid_o,
  output logic [BusDataWidth-1:0]        rdata_o,
  output logic                           uart_wr_en_o,
  output logic [BusDataWidth-1:0]        uart_addr_o,
  output logic [BusDataWidth-1:0]        uart_wdata_o,
  input  logic [BusDataWidth-1:0]        uart_rdata_i
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(LockMaxCycles + 1);

  arb_state_e               state_q, state_d;
  logic [PtrW-1:0]          ptr_q, ptr_d, owner_q, owner_d;
  logic [CntW-1:0]          cnt_q, cnt_d, cnt_nx;
  logic [NumReq-1:0]        blk_q, blk_d;

  logic [NumReq-1:0]        eff_lock, cand, pick_gnt, gnt_raw;
  logic                     pick_vld, prio_hit, any_gnt;
  logic [PtrW-1:0]          win, win_inc, own_inc;
  logic [1:0]               sel_addr;
  logic [BusDataWidth-1:0]  sel_wdata;
  logic [NumReq-1:0]        rvalid_q;
  logic [BusDataWidth-1:0]  rdata_q;

  // A blocked requester's lock request is treated as a plain request.
  assign eff_lock = lock_i & ~blk_q;

  // While locked, only the owner is visible to the picker.
  always_comb begin
    cand = req_i;
    if (state_q == LOCKED) cand = req_i & (NumReq'(1) << owner_q);
  end

  uart_rr_pick #(.NumReq(NumReq)) u_pick (
    .req   (cand),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_vld)
  );

`ifdef UART_ARB_PRIO_EN
  assign prio_hit = (state_q == IDLE_RR) && req_i[0];
`else
  assign prio_hit = 1'b0;
`endif

  always_comb begin
    gnt_raw = pick_gnt;
    if (prio_hit) gnt_raw = NumReq'(1);
    if (!pick_vld && !prio_hit) gnt_raw = '0;
  end

  // No grant can leak out while reset is held. Otherwise it would reach the
  // UART and have side effects.
  assign gnt_o   = rst_i ? '0 : gnt_raw;
  assign any_gnt = |gnt_o;

  always_comb begin
    win = '0;
    for (int i = 0; i < NumReq; i++)
      if (gnt_raw[i]) win = PtrW'(i);
  end

  assign win_inc = (win     == PtrW'(NumReq - 1)) ? '0 : win + 1'b1;
  assign own_inc = (owner_q == PtrW'(NumReq - 1)) ? '0 : owner_q + 1'b1;

  assign sel_addr  = addr_i[2*win +: 2];
  assign sel_wdata = wdata_i[BusDataWidth*win +: BusDataWidth];

  // Idle presents the status offset, never RX data, so nothing is popped.
  assign uart_addr_o  = any_gnt ? BusDataWidth'(sel_addr) : BusDataWidth'(UART_OFF_IDLE);
  assign uart_wr_en_o = any_gnt & we_i[win];
  assign uart_wdata_o = any_gnt ? sel_wdata : '0;

  assign cnt_nx = (cnt_q == CntW'(LockMaxCycles)) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q & lock_i;  // a block clears once lock_i drops
    unique case (state_q)
      IDLE_RR: begin
        if (any_gnt) begin
          if (eff_lock[win]) begin
            if (LockMaxCycles <= 1) begin
              // A single-cycle budget is used up by the grant itself.
              ptr_d      = win_inc;
              blk_d[win] = 1'b1;
            end else begin
              state_d = LOCKED;
              owner_d = win;
              cnt_d   = CntW'(1);
            end
          end else if (!prio_hit) begin
            ptr_d = win_inc;
          end
        end
      end
      LOCKED: begin
        // The budget counts every locked cycle, including cycles where the
        // owner is idle.
        if (!lock_i[owner_q]) begin
          state_d = IDLE_RR;
          ptr_d   = own_inc;
          cnt_d   = '0;
        end else if (cnt_nx >= CntW'(LockMaxCycles)) begin
          state_d        = IDLE_RR;
          ptr_d          = own_inc;
          blk_d[owner_q] = 1'b1;
          cnt_d          = '0;
        end else begin
          cnt_d = cnt_nx;
        end
      end
      default: state_d = IDLE_RR;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE_RR;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end

  // The response path does not depend on lock state. Writes still pulse
  // rvalid, with rdata = 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt_o;
      rdata_q  <= (any_gnt && !we_i[win]) ? uart_rdata_i : '0;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule
